// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - fetch FSM state encodings and shared helpers
package instr_fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int ENTRY_W = 64;

  // Word addresses wrap naturally at 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// rtl/instr_fetch_queue_fetch_fifo.sv - sync FIFO of {instr, pc} entries with flush
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Flush wins over both ends so a redirect leaves a clean, empty queue.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - single-outstanding instruction fetcher feeding a small queue
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int             CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        fetch_pc_next;
  logic [31:0]        mem_addr_next;
  logic               push;
  logic               flush;
  logic               pop;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_addr <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    mem_addr_next = mem_addr;
    push          = 1'b0;
    flush         = 1'b0;

    if (redirect) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc;
    end

    case (state)
      IDLE: begin
        if (!redirect && (count < FULL_COUNT)) begin
          state_next    = WAIT;
          mem_addr_next = fetch_pc;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_next = IDLE;
          if (!redirect) begin
            push          = 1'b1;
            fetch_pc_next = next_word(fetch_pc);
          end
        end else if (redirect) begin
          state_next = DISCARD;
        end
      end
      // The stale request cannot be withdrawn, so wait out its ack and drop it.
      DISCARD: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req     = (state != IDLE);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr_out   = head_data[63:32];
  assign instr_pc    = head_data[31:0];

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({mem_rdata, mem_addr}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .count     (count)
  );

endmodule
